seg7_scan_mux: RTL and testbench

Time-multiplexed display driver that consumes the three 7-segment patterns produced by the two-digit BCD adder stage (d2 = carry/hundreds digit "0"/"1", d1 = tens, d0 = units) and drives them onto one shared segment bus with per-digit active-low anode enables. It captures all three digits at a frame boundary so every frame is consistent, and inserts blanked dead time between digits to prevent ghosting. Optional leading-zero blanking suppresses a "0" in d2, or in d2 and d1.

---
 rtl/seg7_scan_mux.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for three 7-segment digits on a shared active-low bus.
// All three digits and the blanking mode are latched at each frame boundary so a
// frame never mixes old and new values. Every digit's on-time is preceded by blanked
// dead time to suppress ghosting. seg/an/frame_tick are registered outputs.
module seg7_scan_mux #(
  parameter int unsigned ON_CYC   = 50000,
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       lzb,
  input  logic [6:0] d0,
  input  logic [6:0] d1,
  input  logic [6:0] d2,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_tick
);

  localparam int unsigned MaxCyc = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
  // The counter only ever holds a load value of (cycles - 1).
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] DeadLoad = CntW'(DEAD_CYC - 1);
  localparam logic [CntW-1:0] OnLoad   = CntW'(ON_CYC - 1);
  localparam logic [6:0]      Blank    = 7'h7F;
  localparam logic [6:0]      Zero     = 7'h40;

  typedef enum logic {StDead, StOn} phase_e;

  phase_e          phase_q, phase_d;
  logic [1:0]      slot_q, slot_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Set while the scanner is held idle (after reset or while en is low); the first
  // enabled edge out of this state starts a fresh frame with a capture.
  logic            parked_q, parked_d;
  logic            capture;

  logic [6:0]      s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic            s_lzb_q, s_lzb_d;

  logic [6:0]      seg_d;
  logic [2:0]      an_d;
  logic            tick_d;
  logic            blank2, blank1;

  // Scan sequencer: dead/on phase per slot, slot rotation and frame capture.
  always_comb begin
    phase_d  = phase_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    parked_d = parked_q;
    capture  = 1'b0;
    if (!en) begin
      // Parking overrides everything, including a coincident frame boundary.
      phase_d  = StDead;
      slot_d   = 2'd0;
      cnt_d    = DeadLoad;
      parked_d = 1'b1;
    end else if (parked_q) begin
      capture  = 1'b1;
      parked_d = 1'b0;
      phase_d  = StDead;
      slot_d   = 2'd0;
      cnt_d    = DeadLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (phase_q == StDead) begin
      phase_d = StOn;
      cnt_d   = OnLoad;
    end else begin
      phase_d = StDead;
      cnt_d   = DeadLoad;
      if (slot_q == 2'd2) begin
        slot_d  = 2'd0;
        capture = 1'b1;
      end else begin
        slot_d = slot_q + 2'd1;
      end
    end
  end

  // Shadow copies of the digits, refreshed only at capture.
  always_comb begin
    s0_d    = capture ? d0  : s0_q;
    s1_d    = capture ? d1  : s1_q;
    s2_d    = capture ? d2  : s2_q;
    s_lzb_d = capture ? lzb : s_lzb_q;
  end

  // Leading-zero blanking: tens digit only blanks when the hundreds digit does too.
  always_comb begin
    blank2 = s_lzb_d && (s2_d == Zero);
    blank1 = blank2 && (s1_d == Zero);
  end

  // Output decode from next state so outputs line up with the registered state.
  always_comb begin
    seg_d  = Blank;
    an_d   = 3'b111;
    tick_d = capture;
    if (phase_d == StOn) begin
      case (slot_d)
        2'd0: begin
          an_d  = 3'b110;
          seg_d = s0_d;
        end
        2'd1: begin
          an_d  = 3'b101;
          seg_d = blank1 ? Blank : s1_d;
        end
        2'd2: begin
          an_d  = 3'b011;
          seg_d = blank2 ? Blank : s2_d;
        end
        default: begin
          an_d  = 3'b111;
          seg_d = Blank;
        end
      endcase
    end
  end

  // Sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= StDead;
      slot_q   <= 2'd0;
      cnt_q    <= DeadLoad;
      parked_q <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      parked_q <= parked_d;
    end
  end

  // Shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q    <= Blank;
      s1_q    <= Blank;
      s2_q    <= Blank;
      s_lzb_q <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s_lzb_q <= s_lzb_d;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= Blank;
      an         <= 3'b111;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_d;
      an         <= an_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: table of per-cycle frames on a 4/2 instance,
// hand sequences for park/re-enable/async reset, and a BCD-adder sweep on a 1/1 one.
module tb_seg7_scan_mux;

  logic       clk;
  logic       rst_n;
  logic       en, lzb;
  logic [6:0] d0, d1, d2;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_tick;

  logic       f_en, f_lzb;
  logic [6:0] f_d0, f_d1, f_d2;
  logic [6:0] f_seg;
  logic [2:0] f_an;
  logic       f_tick;

  int nvec;
  int nerr;

  seg7_scan_mux #(.ON_CYC(4), .DEAD_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lzb(lzb), .d0(d0), .d1(d1), .d2(d2),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  seg7_scan_mux #(.ON_CYC(1), .DEAD_CYC(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .en(f_en), .lzb(f_lzb), .d0(f_d0), .d1(f_d1), .d2(f_d2),
    .seg(f_seg), .an(f_an), .frame_tick(f_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       en;
    logic       lzb;
    logic [6:0] d0;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [6:0] seg;
    logic [2:0] an;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] enc(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // Expected outputs at position idx (0..17) of an 18-cycle frame (DEAD 2, ON 4).
  task automatic exp_at(input int idx, input logic [6:0] e0, input logic [6:0] e1,
                        input logic [6:0] e2, output logic [6:0] es, output logic [2:0] ea,
                        output logic et);
    int sl;
    int pos;
    sl = idx / 6;
    pos = idx % 6;
    et = (idx == 0);
    es = 7'h7F;
    ea = 3'b111;
    if (pos >= 2) begin
      if (sl == 0) begin ea = 3'b110; es = e0; end
      else if (sl == 1) begin ea = 3'b101; es = e1; end
      else begin ea = 3'b011; es = e2; end
    end
  endtask

  task automatic add_frame(input logic l, input logic [6:0] i0, input logic [6:0] i1,
                           input logic [6:0] i2, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input int chg_idx, input logic [6:0] chg_d1);
    vec_t v;
    for (int i = 0; i < 18; i++) begin
      v.en = 1'b1;
      v.lzb = l;
      v.d0 = i0;
      v.d1 = (i >= chg_idx) ? chg_d1 : i1;
      v.d2 = i2;
      exp_at(i, e0, e1, e2, v.seg, v.an, v.tick);
      vecs.push_back(v);
    end
  endtask

  task automatic check(input string name, input logic [6:0] es, input logic [2:0] ea,
                       input logic et);
    nvec++;
    if (seg !== es || an !== ea || frame_tick !== et) begin
      nerr++;
      $display("FAIL %s: got seg=%h an=%b tick=%b, want seg=%h an=%b tick=%b",
               name, seg, an, frame_tick, es, ea, et);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input int first, input int last);
    logic [6:0] es;
    logic [2:0] ea;
    logic       et;
    for (int i = first; i <= last; i++) begin
      step();
      exp_at(i, e0, e1, e2, es, ea, et);
      check($sformatf("%s[%0d]", name, i), es, ea, et);
    end
  endtask

  // Adder sweep helpers.
  logic [6:0] sw_e0, sw_e1, sw_e2;
  logic [2:0] prev_an;
  logic       inv_bad;

  task automatic set_combo(input int i);
    int a, b, c, s;
    c = i % 2;
    b = (i / 2) % 10;
    a = i / 20;
    s = a + b + c;
    f_d0 = enc(s % 10);
    f_d1 = enc((s / 10) % 10);
    f_d2 = enc(s / 100);
    f_lzb = ((i / 3) % 2) != 0;
  endtask

  task automatic fast_step();
    step();
    if ($countones(~f_an) > 1) inv_bad = 1'b1;
    if (prev_an != 3'b111 && f_an != 3'b111 && f_an != prev_an) inv_bad = 1'b1;
    prev_an = f_an;
  endtask

  logic [6:0] got [6];
  logic [2:0] gan [6];
  logic       gtk [6];
  logic       ok;
  int         waited;

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    en = 1'b1;
    lzb = 1'b0;
    d0 = 7'h12;
    d1 = 7'h30;
    d2 = 7'h40;
    f_en = 1'b1;
    f_lzb = 1'b0;
    f_d0 = 7'h7F;
    f_d1 = 7'h7F;
    f_d2 = 7'h7F;
    prev_an = 3'b111;
    inv_bad = 1'b0;

    #12;
    check("reset", 7'h7F, 3'b111, 1'b0);
    rst_n = 1'b1;

    // Frame table.
    add_frame(1'b0, 7'h12, 7'h30, 7'h40, 7'h12, 7'h30, 7'h40, 18, 7'h00);
    add_frame(1'b0, 7'h12, 7'h30, 7'h40, 7'h12, 7'h30, 7'h40, 18, 7'h00);
    add_frame(1'b1, 7'h12, 7'h30, 7'h40, 7'h12, 7'h30, 7'h7F, 18, 7'h00);
    add_frame(1'b1, 7'h12, 7'h40, 7'h40, 7'h12, 7'h7F, 7'h7F, 18, 7'h00);
    add_frame(1'b1, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 18, 7'h00);
    add_frame(1'b1, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h79, 18, 7'h00);
    add_frame(1'b1, 7'h12, 7'h7F, 7'h40, 7'h12, 7'h7F, 7'h7F, 18, 7'h00);
    // d1 changes during slot 1 ON: this frame keeps 30, the next shows 79.
    add_frame(1'b0, 7'h12, 7'h30, 7'h40, 7'h12, 7'h30, 7'h40, 8, 7'h79);
    add_frame(1'b0, 7'h12, 7'h79, 7'h40, 7'h12, 7'h79, 7'h40, 18, 7'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en;
      lzb = vecs[i].lzb;
      d0 = vecs[i].d0;
      d1 = vecs[i].d1;
      d2 = vecs[i].d2;
      step();
      check($sformatf("vec%0d", i), vecs[i].seg, vecs[i].an, vecs[i].tick);
    end

    // Park during slot 1 ON, change d0 while parked, then re-enable.
    lzb = 1'b0;
    d0 = 7'h12;
    d1 = 7'h30;
    d2 = 7'h40;
    check_frame("pre_park", 7'h12, 7'h30, 7'h40, 0, 8);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) d0 = 7'h24;
      step();
      check($sformatf("park%0d", i), 7'h7F, 3'b111, 1'b0);
    end
    en = 1'b1;
    check_frame("reenable", 7'h24, 7'h30, 7'h40, 0, 17);

    // en falls exactly at the frame boundary: no capture, no tick.
    en = 1'b0;
    step();
    check("park_boundary", 7'h7F, 3'b111, 1'b0);
    step();
    check("park_hold", 7'h7F, 3'b111, 1'b0);
    en = 1'b1;
    check_frame("boundary_reen", 7'h24, 7'h30, 7'h40, 0, 2);

    // Asynchronous reset mid-ON, checked with no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 7'h7F, 3'b111, 1'b0);
    d0 = 7'h12;
    #2;
    rst_n = 1'b1;
    check_frame("rst_frame", 7'h12, 7'h30, 7'h40, 0, 17);
    check_frame("rst_frame2", 7'h12, 7'h30, 7'h40, 0, 0);
    // Reset while frame_tick is high clears it immediately.
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_tick", 7'h7F, 3'b111, 1'b0);
    #1;
    rst_n = 1'b1;

    // Adder sweep on the 1/1 instance (frame = 6 cycles).
    waited = 0;
    step();
    while (f_tick !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    nvec++;
    if (f_tick !== 1'b1) begin
      nerr++;
      $display("FAIL sweep_sync: tick=%b after %0d cycles, want 1", f_tick, waited);
    end else begin
      prev_an = f_an;
      set_combo(0);
      for (int p = 1; p < 6; p++) fast_step();
      for (int i = 0; i < 2000; i++) begin
        fast_step();
        got[0] = f_seg; gan[0] = f_an; gtk[0] = f_tick;
        if (i < 1999) set_combo(i + 1);
        for (int p = 1; p < 6; p++) begin
          fast_step();
          got[p] = f_seg; gan[p] = f_an; gtk[p] = f_tick;
        end
        // Expected digits of combo i (captured at this frame's tick).
        set_combo_exp(i);
        ok = (gtk[0] === 1'b1) && (gan[0] === 3'b111) && (got[0] === 7'h7F) &&
             (gtk[1] === 1'b0) && (gan[1] === 3'b110) && (got[1] === sw_e0) &&
             (gan[2] === 3'b111) && (got[2] === 7'h7F) &&
             (gan[3] === 3'b101) && (got[3] === sw_e1) &&
             (gan[4] === 3'b111) && (got[4] === 7'h7F) &&
             (gan[5] === 3'b011) && (got[5] === sw_e2);
        nvec++;
        if (!ok) begin
          nerr++;
          $display("FAIL sweep%0d: got tick=%b seg=%h/%h/%h an=%b/%b/%b, want seg=%h/%h/%h",
                   i, gtk[0], got[1], got[3], got[5], gan[1], gan[3], gan[5],
                   sw_e0, sw_e1, sw_e2);
        end
        nvec++;
        if (inv_bad) begin
          nerr++;
          $display("FAIL sweep_an%0d: an overlap or digit-to-digit without blank, last an=%b",
                   i, f_an);
          inv_bad = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  task automatic set_combo_exp(input int i);
    int a, b, c, s;
    logic l;
    logic [6:0] x0, x1, x2;
    c = i % 2;
    b = (i / 2) % 10;
    a = i / 20;
    s = a + b + c;
    l = ((i / 3) % 2) != 0;
    x0 = enc(s % 10);
    x1 = enc((s / 10) % 10);
    x2 = enc(s / 100);
    sw_e0 = x0;
    sw_e2 = (l && x2 == 7'h40) ? 7'h7F : x2;
    sw_e1 = (l && x2 == 7'h40 && x1 == 7'h40) ? 7'h7F : x1;
  endtask

endmodule
